idct_2d_stream: RTL
===================

# idct_2d_stream

Streaming 8x8 two-dimensional inverse DCT: the decoder-side counterpart of the forward 2D DCT. It accepts one dequantized coefficient row per handshake, runs a 1D IDCT on each row into an internal transpose buffer, then runs a 1D IDCT on each buffered column and emits one reconstructed pixel column per beat. It sits between dequantization and the pixel sink in the decompression path.

## Interface
- DATA_W, 16: signed width of each input coefficient and output sample.
- COEF_FRAC, 13: fractional bits of the fixed-point cosine constants.
- aclk  in  1  clock; all state changes on the rising edge.
- areset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input row valid.
- in_ready  out  1  block can accept a row.
- in_data  in  8*DATA_W  coefficient row r; lane i at [i*DATA_W +: DATA_W] = X[r][i], two's complement.
- out_valid  out  1  output column valid.
- out_ready  in  1  sink accepts a column.
- out_data  out  8*DATA_W  pixel column j; lane i = x[i][j].
- out_last  out  1  high on column 7 of a block.

## Operation
- States: FILL (row_cnt 0..7), DRAIN (col_cnt 0..7). Reset state is FILL with both counters at 0.
- in_ready = (state == FILL). Row handshake: in_valid & in_ready.
- On each row handshake, write 1D-IDCT(in_data) to buffer row row_cnt and increment row_cnt. On the 8th handshake, go to DRAIN with col_cnt = 0.
- DRAIN: the output register loads when it is empty or (out_valid & out_ready). Each load takes 1D-IDCT of buffer column col_cnt, sets out_last = (col_cnt == 7), and increments col_cnt. The load of column 7 returns the state to FILL with row_cnt = 0, which frees the buffer.
- 1D IDCT: y[n] = sum over k of X[k]*W[k][n], where W[k][n] = round(2^COEF_FRAC * c(k)/2 * cos((2n+1)kπ/16)), c(0) = 1/√2, c(k>0) = 1.
- Products and sums are full precision. Add 2^(COEF_FRAC-1), arithmetic-shift right by COEF_FRAC (floor), then saturate to DATA_W signed. The row and column passes use identical arithmetic.
- out_data, out_valid and out_last hold stable while out_valid & !out_ready.
- Reset at any time discards any partial block and any pending output.

## Timing
- Reset values: out_valid = 0, out_last = 0, out_data = 0, in_ready = 1.
- If the 8th row handshake occurs in cycle t: DRAIN in t+1, column 0 is valid in t+2, and with out_ready held high, column 7 is valid in t+9.
- in_ready is 0 during t+1..t+8 (8 cycles) and 1 again in t+9, while column 7 is still presented.
- Best-case throughput is one block per 16 cycles. Backpressure stalls DRAIN only; the buffer is never overwritten before it is read.

## Configuration
- IDCT_LEVEL_SHIFT_EN defined: each column-pass result, after saturation, has 128 added and is clamped to 0..255. The result is zero-extended into its DATA_W lane.
- Not defined: out_data carries the signed saturated column-pass result unchanged.

## Structure
- Package idct_pkg holds:
  - the 8x8 W[k][n] constant table, parameterized by COEF_FRAC;
  - the state enum {FILL, DRAIN};
  - the lane count of 8.
- Sub-module idct_1d is combinational: 8 lanes in, 8 lanes out, containing the rounding and saturation. It is instantiated twice, once for the row pass and once for the column pass.
- The transpose buffer is an 8x8 register array inside the top module.

## Test plan
- DC block: X[0][0] = 64, all other coefficients 0 -> all 64 outputs = 8 (136 with IDCT_LEVEL_SHIFT_EN). The intermediate row-0 value is 23.
- Saturation: X[0][0] = 32767 -> all outputs 4095 (255 with shift). X[0][0] = -2048 -> all outputs -256 (0 with shift).
- Latency and throughput: 8 back-to-back rows with out_ready held at 1 -> out_valid at t+2; out_last only at t+9; in_ready low for exactly 8 cycles.
- Backpressure: drop out_ready for 3 cycles after column 2 is presented -> column 2 held stable, no beat lost or duplicated, in_ready stays 0.
- Reset mid-fill: assert areset after 5 rows -> outputs return to reset values. The next 8 rows form a fresh block whose outputs match a bit-exact model of that block alone.
- Random blocks: 1000 blocks with random coefficients in ±1024 and random in_valid/out_ready -> outputs bit-exact against the fixed-point software model.

Source files
------------

// File: rtl/idct_pkg.sv
// Shared definitions for the streaming 8x8 inverse DCT: lane count, FSM state
// type and the W[k][n] cosine coefficient table scaled by 2^frac.
package idct_pkg;

  localparam int unsigned LANES = 8;

  typedef enum logic {FILL, DRAIN} state_t;

  // c(k)/2 * cos(m*pi/16) scaled by 2^30; entry 0 carries the k=0 term 1/(2*sqrt(2)).
  function automatic int cos_q30(input int unsigned m);
    case (m)
      0:       return 379625062;
      1:       return 526555088;
      2:       return 496004047;
      3:       return 446391849;
      4:       return 379625062;
      5:       return 298269498;
      6:       return 205451603;
      7:       return 104738319;
      default: return 0;
    endcase
  endfunction

  // W[k][n] = round(2^frac * c(k)/2 * cos((2n+1)k*pi/16)); valid for frac <= 29.
  // The angle is folded into 0..8 (x pi/16) using cosine symmetry, then rounded
  // half away from zero from the 2^30 reference.
  function automatic int w_coef(input int unsigned k, input int unsigned n,
                                input int unsigned frac);
    int unsigned m;
    int          mag;
    bit          neg;
    m   = 0;
    neg = 1'b0;
    if (k != 0) begin
      m = ((2 * n + 1) * k) % 32;
      if (m > 16) m = 32 - m;
      if (m > 8) begin
        m   = 16 - m;
        neg = 1'b1;
      end
    end
    mag = cos_q30(m);
    mag = (mag + (1 << (29 - frac))) >>> (30 - frac);
    return neg ? -mag : mag;
  endfunction

endpackage

// File: rtl/idct_2d_stream_idct_1d.sv
// Combinational 8-point 1D IDCT: full-precision multiply-accumulate against
// the W table, round-half-up, floor shift by COEF_FRAC, saturate to DATA_W.
import idct_pkg::*;

module idct_1d #(
  parameter int DATA_W    = 16,
  parameter int COEF_FRAC = 13
) (
  input  logic [LANES*DATA_W-1:0] din,
  output logic [LANES*DATA_W-1:0] dout
);

  localparam int ACC_W = DATA_W + COEF_FRAC + 4;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (DATA_W - 1)));

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] shf;

  // Per output lane: dot product with column n of W, then round and clamp.
  always_comb begin
    dout = '0;
    acc  = '0;
    shf  = '0;
    for (int unsigned n = 0; n < LANES; n++) begin
      acc = '0;
      acc[COEF_FRAC-1] = 1'b1;
      for (int unsigned k = 0; k < LANES; k++) begin
        acc = acc + ACC_W'($signed(din[k*DATA_W +: DATA_W]))
                  * ACC_W'(w_coef(k, n, COEF_FRAC));
      end
      shf = acc >>> COEF_FRAC;
      if (shf > SAT_MAX)
        dout[n*DATA_W +: DATA_W] = {1'b0, {(DATA_W-1){1'b1}}};
      else if (shf < SAT_MIN)
        dout[n*DATA_W +: DATA_W] = {1'b1, {(DATA_W-1){1'b0}}};
      else
        dout[n*DATA_W +: DATA_W] = shf[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/idct_2d_stream.sv
// Streaming 8x8 2D inverse DCT. Rows are transformed on entry into a transpose
// buffer; once eight rows are held, columns are transformed and emitted one per
// beat. Optional macro IDCT_LEVEL_SHIFT_EN adds 128 and clamps outputs to 0..255.
import idct_pkg::*;

module idct_2d_stream #(
  parameter int DATA_W    = 16,
  parameter int COEF_FRAC = 13
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic                    out_last
);

  state_t                    state;
  logic [2:0]                row_cnt;
  logic [2:0]                col_cnt;
  logic signed [DATA_W-1:0]  tbuf [LANES][LANES];
  logic [LANES*DATA_W-1:0]   row_res;
  logic [LANES*DATA_W-1:0]   col_in;
  logic [LANES*DATA_W-1:0]   col_res;
  logic [LANES*DATA_W-1:0]   col_px;
  logic                      row_hs;
  logic                      out_load;

  assign in_ready = (state == FILL);
  assign row_hs   = in_valid & in_ready;
  assign out_load = (state == DRAIN) & (~out_valid | out_ready);

  idct_1d #(.DATA_W(DATA_W), .COEF_FRAC(COEF_FRAC)) u_row (
    .din  (in_data),
    .dout (row_res)
  );

  // Gather buffer column col_cnt as the column-pass input vector.
  always_comb begin
    col_in = '0;
    for (int unsigned i = 0; i < LANES; i++)
      col_in[i*DATA_W +: DATA_W] = tbuf[i][col_cnt];
  end

  idct_1d #(.DATA_W(DATA_W), .COEF_FRAC(COEF_FRAC)) u_col (
    .din  (col_in),
    .dout (col_res)
  );

`ifdef IDCT_LEVEL_SHIFT_EN
  logic signed [DATA_W:0] ls;

  // Level shift each column-pass sample into the unsigned 8-bit pixel range.
  always_comb begin
    col_px = '0;
    ls     = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      ls = (DATA_W+1)'($signed(col_res[i*DATA_W +: DATA_W])) + (DATA_W+1)'(128);
      if (ls < 0)
        col_px[i*DATA_W +: DATA_W] = '0;
      else if (ls > 255)
        col_px[i*DATA_W +: DATA_W] = DATA_W'(255);
      else
        col_px[i*DATA_W +: DATA_W] = DATA_W'(ls[7:0]);
    end
  end
`else
  // Signed column-pass result passes straight through.
  always_comb col_px = col_res;
`endif

  // Transpose buffer: row-pass results land in row row_cnt on each handshake.
  always_ff @(posedge aclk) begin
    if (row_hs)
      for (int unsigned i = 0; i < LANES; i++)
        tbuf[row_cnt][i] <= $signed(row_res[i*DATA_W +: DATA_W]);
  end

  // FILL/DRAIN sequencing and the registered output stage.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state     <= FILL;
      row_cnt   <= '0;
      col_cnt   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      if (out_load) begin
        out_valid <= 1'b1;
        out_data  <= col_px;
        out_last  <= (col_cnt == 3'd7);
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      case (state)
        FILL: begin
          if (row_hs) begin
            row_cnt <= row_cnt + 3'd1;
            if (row_cnt == 3'd7) begin
              state   <= DRAIN;
              col_cnt <= '0;
            end
          end
        end
        DRAIN: begin
          if (out_load) begin
            col_cnt <= col_cnt + 3'd1;
            if (col_cnt == 3'd7) begin
              state   <= FILL;
              row_cnt <= '0;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule
